// File: rtl/isla_calib_pkg.sv
// Shared types and constants for the ISLA IDELAY calibration sequencer.
package isla_calib_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SETUP,
        ST_PULSE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_APPLY_SETUP,
        ST_APPLY_PULSE,
        ST_APPLY_SETTLE,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_NUM_LANES    = 8;
    localparam int unsigned DEF_TAP_BITS     = 5;
    localparam logic [15:0] DEF_TEST_PATTERN = 16'hA5C3;

    // Run lengths must hold the full tap count, one bit wider than a tap.
    function automatic int unsigned run_len_bits(input int unsigned tap_bits);
        return tap_bits + 1;
    endfunction

endpackage

// File: rtl/isla_delay_calib_eye_tracker.sv
// Per-lane passing-window tracker: current and best run, plus the centre tap.
module isla_eye_tracker
    import isla_calib_pkg::*;
#(
    parameter int unsigned TAP_BITS    = DEF_TAP_BITS,
    parameter int unsigned DEFAULT_TAP = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                pass,
    input  logic                tap_strobe,
    input  logic [TAP_BITS-1:0] tap,
    output logic [TAP_BITS-1:0] centre_c,
    output logic                found_c
);

    localparam int unsigned LW = run_len_bits(TAP_BITS);

    logic [TAP_BITS-1:0] cur_start;
    logic [TAP_BITS-1:0] best_start;
    logic [LW-1:0]       cur_len;
    logic [LW-1:0]       best_len;
    logic [TAP_BITS-1:0] cur_start_nxt;
    logic [LW-1:0]       cur_len_inc;

    // Extended run candidate if this tap passes.
    always_comb begin
        cur_len_inc   = cur_len + LW'(1);
        cur_start_nxt = (cur_len == '0) ? tap : cur_start;
    end

    // Run bookkeeping; best only moves on a strictly longer run so ties keep the earliest window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (clear) begin
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (tap_strobe) begin
            if (pass) begin
                cur_start <= cur_start_nxt;
                cur_len   <= cur_len_inc;
                if (cur_len_inc > best_len) begin
                    best_start <= cur_start_nxt;
                    best_len   <= cur_len_inc;
                end
            end else begin
                cur_len <= '0;
            end
        end
    end

    // Centre of the best window, rounding toward its start.
    always_comb begin
        found_c  = (best_len != '0);
        centre_c = found_c ? (best_start + TAP_BITS'((best_len - LW'(1)) >> 1))
                           : TAP_BITS'(DEFAULT_TAP);
    end

endmodule

// File: rtl/isla_delay_calib.sv
// IDELAY calibration sequencer: sweeps every tap per lane and loads the centre of the widest eye.
module isla_delay_calib
    import isla_calib_pkg::*;
#(
    parameter int unsigned              NUM_LANES     = DEF_NUM_LANES,
    parameter int unsigned              TAP_BITS      = DEF_TAP_BITS,
    parameter logic [2*NUM_LANES-1:0]   TEST_PATTERN  = DEF_TEST_PATTERN,
    parameter int unsigned              SETTLE_CYCLES = 16,
    parameter int unsigned              SAMPLE_COUNT  = 64,
    parameter int unsigned              DEFAULT_TAP   = 0
) (
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [2*NUM_LANES-1:0]        adc_data,
    input  logic                          adc_data_valid,
    input  logic                          delay_rdy,
    output logic [TAP_BITS-1:0]           delay_reg,
    output logic [NUM_LANES-1:0]          delay_select,
    output logic                          delay_load,
    output logic                          busy,
    output logic                          done,
    output logic [NUM_LANES-1:0]          lane_fail,
    output logic [NUM_LANES*TAP_BITS-1:0] lane_tap
);

    localparam int unsigned DW        = 2 * NUM_LANES;
    localparam int unsigned LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CNT_MAX   = (SETTLE_CYCLES > SAMPLE_COUNT) ? SETTLE_CYCLES : SAMPLE_COUNT;
    localparam int unsigned CNT_BITS  = $clog2(CNT_MAX + 1);

    state_t               state;
    state_t               state_nxt;
    logic [LANE_BITS-1:0] lane;
    logic [TAP_BITS-1:0]  tap;
    logic [CNT_BITS-1:0]  cnt;
    logic                 err;

    logic                 settle_last_c;
    logic                 sample_last_c;
    logic                 last_lane_c;
    logic                 mismatch_c;
    logic [DW-1:0]        lane_mask_c;
    logic                 trk_clear_c;
    logic                 trk_strobe_c;
    logic [TAP_BITS-1:0]  centre_c;
    logic                 found_c;

    // Counter terminal conditions and selected-lane pattern compare.
    always_comb begin
        settle_last_c = (cnt == CNT_BITS'(SETTLE_CYCLES - 1));
        sample_last_c = adc_data_valid && (cnt == CNT_BITS'(SAMPLE_COUNT - 1));
        last_lane_c   = (lane == LANE_BITS'(NUM_LANES - 1));
        lane_mask_c   = DW'(2'b11) << {lane, 1'b0};
        mismatch_c    = |((adc_data ^ TEST_PATTERN) & lane_mask_c);
        trk_clear_c   = (state == ST_SETUP) && (tap == '0);
        trk_strobe_c  = (state == ST_EVAL);
    end

    isla_eye_tracker #(
        .TAP_BITS   (TAP_BITS),
        .DEFAULT_TAP(DEFAULT_TAP)
    ) u_eye (
        .clk       (sys_clk),
        .rst       (rst),
        .clear     (trk_clear_c),
        .pass      (!err),
        .tap_strobe(trk_strobe_c),
        .tap       (tap),
        .centre_c  (centre_c),
        .found_c   (found_c)
    );

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:         if (start) state_nxt = ST_WAIT_RDY;
            ST_WAIT_RDY:     if (delay_rdy) state_nxt = ST_SETUP;
            ST_SETUP:        state_nxt = ST_PULSE;
            ST_PULSE:        state_nxt = ST_SETTLE;
            ST_SETTLE:       if (settle_last_c) state_nxt = ST_SAMPLE;
            ST_SAMPLE:       if (sample_last_c) state_nxt = ST_EVAL;
            ST_EVAL:         state_nxt = (&tap) ? ST_APPLY_SETUP : ST_SETUP;
            ST_APPLY_SETUP:  state_nxt = ST_APPLY_PULSE;
            ST_APPLY_PULSE:  state_nxt = ST_APPLY_SETTLE;
            ST_APPLY_SETTLE: if (settle_last_c) state_nxt = last_lane_c ? ST_DONE : ST_SETUP;
            ST_DONE:         state_nxt = ST_IDLE;
            default:         state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: sweep position, counters, delay controls and results.
    // Tap/select are registered at the end of SETUP and the strobe at the end of PULSE,
    // so the delay block always sees a full cycle of stable data before the load edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            delay_load   <= 1'b0;
            delay_reg    <= '0;
            delay_select <= '0;
            lane_fail    <= '0;
            lane_tap     <= '0;
            lane         <= '0;
            tap          <= '0;
            cnt          <= '0;
            err          <= 1'b0;
        end else begin
            done       <= (state_nxt == ST_DONE);
            delay_load <= (state == ST_PULSE) || (state == ST_APPLY_PULSE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        lane_fail <= '0;
                        lane_tap  <= '0;
                        lane      <= '0;
                        tap       <= '0;
                    end
                end
                ST_SETUP: begin
                    delay_reg    <= tap;
                    delay_select <= NUM_LANES'(1) << lane;
                    cnt          <= '0;
                end
                ST_SETTLE: begin
                    cnt <= settle_last_c ? '0 : cnt + CNT_BITS'(1);
                    err <= 1'b0;
                end
                ST_SAMPLE: begin
                    if (adc_data_valid) begin
                        cnt <= cnt + CNT_BITS'(1);
                        if (mismatch_c) err <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    tap <= tap + TAP_BITS'(1);
                end
                ST_APPLY_SETUP: begin
                    delay_reg    <= centre_c;
                    delay_select <= NUM_LANES'(1) << lane;
                    cnt          <= '0;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (LANE_BITS'(i) == lane) begin
                            lane_tap[i*TAP_BITS +: TAP_BITS] <= centre_c;
                            lane_fail[i]                     <= !found_c;
                        end
                    end
                end
                ST_APPLY_SETTLE: begin
                    cnt <= cnt + CNT_BITS'(1);
                    if (settle_last_c) begin
                        cnt <= '0;
                        if (!last_lane_c) begin
                            lane <= lane + LANE_BITS'(1);
                            tap  <= '0;
                        end
                    end
                end
                ST_DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_isla_delay_calib.sv
// Bench for isla_delay_calib: behavioural delay line + ADC pattern model, scoreboarded results.
module tb_isla_delay_calib;

    localparam int unsigned NL       = 8;
    localparam int unsigned TB       = 5;
    localparam int unsigned S        = 2;
    localparam int unsigned N        = 4;
    localparam int          PER_TAP  = 3 + S + N;
    localparam int          RUN_CYC  = 2 + NL * ((1 << TB) * PER_TAP + 2 + S);
    localparam int          LOADS    = NL * ((1 << TB) + 1);
    localparam int          TMO      = 20000;
    localparam logic [15:0] PAT      = 16'hA5C3;

    typedef struct packed {
        logic [7:0][31:0] m;
        logic [7:0][4:0]  t;
        logic [7:0]       f;
    } vec_t;

    typedef struct packed {
        logic [39:0] taps;
        logic [7:0]  fail;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] adc_data;
    logic        adc_data_valid;
    logic        delay_rdy;
    logic [4:0]  delay_reg;
    logic [7:0]  delay_select;
    logic        delay_load;
    logic        busy;
    logic        done;
    logic [7:0]  lane_fail;
    logic [39:0] lane_tap;

    int   checks;
    int   failures;
    vec_t tv [6];
    vec_t cur_vec;
    exp_t sb [$];
    logic [4:0] cur_tap [8];

    always #5 clk = ~clk;

    isla_delay_calib #(
        .NUM_LANES    (NL),
        .TAP_BITS     (TB),
        .TEST_PATTERN (PAT),
        .SETTLE_CYCLES(S),
        .SAMPLE_COUNT (N),
        .DEFAULT_TAP  (0)
    ) dut (
        .sys_clk       (clk),
        .rst           (rst),
        .start         (start),
        .adc_data      (adc_data),
        .adc_data_valid(adc_data_valid),
        .delay_rdy     (delay_rdy),
        .delay_reg     (delay_reg),
        .delay_select  (delay_select),
        .delay_load    (delay_load),
        .busy          (busy),
        .done          (done),
        .lane_fail     (lane_fail),
        .lane_tap      (lane_tap)
    );

    // Delay line model: selected lanes take the tap on the load rising edge.
    always @(posedge delay_load) begin
        for (int i = 0; i < 8; i++)
            if (delay_select[i]) cur_tap[i] <= delay_reg;
    end

    // ADC model: pattern bits when the lane's tap is inside its eye, inverted otherwise or when invalid.
    always_comb begin
        adc_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (adc_data_valid && cur_vec.m[i][cur_tap[i]])
                adc_data[2*i +: 2] = PAT[2*i +: 2];
            else
                adc_data[2*i +: 2] = ~PAT[2*i +: 2];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"},         64'(busy),         64'd0);
        check({tag, " done"},         64'(done),         64'd0);
        check({tag, " delay_load"},   64'(delay_load),   64'd0);
        check({tag, " delay_reg"},    64'(delay_reg),    64'd0);
        check({tag, " delay_select"}, 64'(delay_select), 64'd0);
        check({tag, " lane_fail"},    64'(lane_fail),    64'd0);
        check({tag, " lane_tap"},     64'(lane_tap),     64'd0);
    endtask

    function automatic vec_t all_pass();
        vec_t v;
        v.m = {8{32'hFFFF_FFFF}};
        v.t = {8{5'd15}};
        v.f = 8'h00;
        return v;
    endfunction

    // One calibration run; vmode 1 = valid at 25% duty, rdy_low = cycles delay_rdy stays low,
    // restart_at = cycle of an extra start pulse (-1 for none).
    task automatic do_run(input int vmode, input int rdy_low, input int restart_at, input string tag);
        int   cyc;
        int   loads;
        int   dones;
        int   early;
        int   done_cyc;
        logic prev_load;
        exp_t e;
        e.taps = cur_vec.t;
        e.fail = cur_vec.f;
        sb.push_back(e);
        cyc = 0; loads = 0; dones = 0; early = 0; done_cyc = -1; prev_load = 1'b0;
        @(negedge clk);
        delay_rdy      = (rdy_low == 0);
        adc_data_valid = 1'b1;
        start          = 1'b1;
        while (cyc < TMO) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, " busy_after_start"}, 64'(busy), 64'd1);
            if (delay_load && !prev_load) begin
                loads++;
                if (!delay_rdy) early++;
            end
            prev_load = delay_load;
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    if (sb.size() == 0) begin
                        check({tag, " scoreboard_empty"}, 64'd0, 64'd1);
                    end else begin
                        e = sb.pop_front();
                        check({tag, " lane_tap"},  64'(lane_tap),  64'(e.taps));
                        check({tag, " lane_fail"}, 64'(lane_fail), 64'(e.fail));
                    end
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check({tag, " busy_after_done"}, 64'(busy), 64'd0);
                check({tag, " select_held"}, 64'(delay_select), 64'h80);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 3) break;
            delay_rdy      = (cyc >= rdy_low);
            start          = (cyc == restart_at);
            adc_data_valid = (vmode == 0) ? 1'b1 : (cyc % 4 == 0);
        end
        start          = 1'b0;
        adc_data_valid = 1'b1;
        if (done_cyc < 0) begin
            check({tag, " done_timeout"}, 64'd0, 64'd1);
            if (sb.size() > 0) e = sb.pop_front();
        end
        check({tag, " done_pulses"}, 64'(dones), 64'd1);
        check({tag, " load_edges"},  64'(loads), 64'(LOADS));
        check({tag, " early_loads"}, 64'(early), 64'd0);
        if (vmode == 0)
            check({tag, " done_cycle"}, 64'(done_cyc),
                  64'(RUN_CYC + ((rdy_low > 0) ? rdy_low - 1 : 0)));
    endtask

    initial begin
        vec_t v;
        int   cyc;
        int   l2;
        int   hold;
        logic pl;
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; adc_data_valid = 1'b1; delay_rdy = 1'b1;
        for (int i = 0; i < 8; i++) cur_tap[i] = 5'd0;

        v = all_pass(); tv[0] = v;
        v = all_pass(); v.m[3] = 32'h0003_FC00; v.t[3] = 5'd13; tv[1] = v;
        v = all_pass(); v.m[0] = 32'h00F0_003C; v.t[0] = 5'd3;  tv[2] = v;
        v = all_pass(); v.m[0] = 32'h01F0_003C; v.t[0] = 5'd22; tv[3] = v;
        v = all_pass(); v.m[5] = 32'h0000_0000; v.t[5] = 5'd0;  v.f = 8'h20; tv[4] = v;
        v = all_pass(); v.m[1] = 32'h0000_0001; v.t[1] = 5'd0;
        v.m[7] = 32'h8000_0000; v.t[7] = 5'd31; tv[5] = v;
        cur_vec = tv[0];

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            cur_vec = tv[i];
            do_run(0, 0, -1, $sformatf("vec%0d", i));
        end

        cur_vec = tv[0];
        do_run(0, 50, 600, "rdy_low_restart");

        cur_vec = tv[1];
        do_run(1, 0, -1, "valid25");

        // Abort with reset while lane 2 is sampling.
        cur_vec = tv[1];
        @(negedge clk);
        start = 1'b1;
        cyc = 0; l2 = 0; hold = -1; pl = 1'b0;
        while (cyc < TMO && hold != 0) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (delay_load && !pl && delay_select == 8'h04) l2++;
            pl = delay_load;
            if (hold > 0) hold--;
            else if (hold < 0 && l2 == 5) hold = 3;
            adc_data_valid = (cyc % 4 == 0);
        end
        if (hold != 0) check("mid_reset_timeout", 64'd0, 64'd1);
        check("mid_reset lanes_done_before", 64'(lane_tap[9:0]), 64'h1EF);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        adc_data_valid = 1'b1;

        cur_vec = tv[0];
        do_run(0, 0, -1, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/isla_delay_calib.md
# isla_delay_calib

Automatic IDELAY calibration sequencer for one ISLA ADC channel. It sits in the `sys_clk` domain in front of the channel's per-lane delay control (`adc0_delay_reg` / `adc0_delay_select` / `adc0_delay_load`). For each LVDS lane it sweeps every tap, checks the returned data against the ADC's fixed test pattern, finds the widest passing window, and loads that window's centre tap. Software starts it with one pulse and reads back the per-lane result and fail flags.

## Interface
Parameters:
- `NUM_LANES`, 8, number of LVDS data lanes; each lane carries 2 bits per word.
- `TAP_BITS`, 5, delay tap width; the sweep covers taps 0..2^TAP_BITS-1.
- `TEST_PATTERN`, 16'hA5C3, expected ADC word while the ADC test-pattern mode is on.
- `SETTLE_CYCLES`, 16, cycles waited after each tap load before sampling (≥1).
- `SAMPLE_COUNT`, 64, valid samples compared per tap (≥1).
- `DEFAULT_TAP`, 0, tap applied to a lane that has no passing tap.

Ports:
- `sys_clk`  in  1  clock; the only clock.
- `rst`  in  1  reset; asynchronous assert, active-high.
- `start`  in  1  single-cycle request; ignored while `busy`.
- `adc_data`  in  2*NUM_LANES  ADC word, already in the `sys_clk` domain; lane i is bits {2i+1, 2i}.
- `adc_data_valid`  in  1  qualifies `adc_data`.
- `delay_rdy`  in  1  IDELAYCTRL ready.
- `delay_reg`  out  TAP_BITS  tap value to load.
- `delay_select`  out  NUM_LANES  one-hot lane select.
- `delay_load`  out  1  load strobe; the delay block acts on its rising edge.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when calibration finishes.
- `lane_fail`  out  NUM_LANES  bit i set means lane i had no passing tap.
- `lane_tap`  out  NUM_LANES*TAP_BITS  applied tap per lane; lane i is at [i*TAP_BITS +: TAP_BITS].

## Operation
- States: IDLE → WAIT_RDY → SETUP → PULSE → SETTLE → SAMPLE → EVAL → (SETUP for the next tap | APPLY_SETUP) → APPLY_PULSE → APPLY_SETTLE → (SETUP for lane+1, tap 0 | DONE) → IDLE.
- IDLE + `start`:
  - Clear `lane_fail` and `lane_tap`.
  - Set lane=0, tap=0.
  - Enter WAIT_RDY.
- WAIT_RDY: hold until `delay_rdy`=1, with no timeout.
- SETUP (1 cycle): register `delay_reg`=tap and `delay_select`=1<<lane.
- PULSE (1 cycle): `delay_load`=1. In every other state `delay_load`=0, so each load is a clean 0→1 edge.
- SETTLE: count SETTLE_CYCLES cycles; `adc_data` is ignored.
- SAMPLE:
  - Count SAMPLE_COUNT cycles with `adc_data_valid`=1.
  - Set a sticky error flag if lane bits ≠ the matching TEST_PATTERN bits on any valid cycle.
  - Invalid cycles are neither counted nor checked.
- EVAL (1 cycle): tap passes if the error flag is clear.
- Run tracking per lane:
  - Track the current run (start, length) and the best run (start, length). Lengths are TAP_BITS+1 bits wide.
  - On pass: the run starts here if the current length is 0; increment the current length; if the new current length is strictly greater than the best length, copy current into best. On a tie the earliest window wins.
  - On fail: current length = 0.
  - All run registers clear at tap 0 of every lane.
- After the last tap:
  - If best length > 0: centre = best_start + (best_len-1)>>1.
  - Otherwise: centre = DEFAULT_TAP and set `lane_fail[lane]`.
- Apply:
  - APPLY_SETUP / APPLY_PULSE load the centre tap, the same way as SETUP / PULSE.
  - APPLY_SETTLE waits SETTLE_CYCLES.
  - `lane_tap[lane]` is written in APPLY_SETUP.
- DONE (1 cycle): `done`=1, `busy`=0 on the next cycle. Results hold until the next accepted `start`.
- `delay_select` keeps its last value after DONE.
- Reset at any point returns to IDLE. It does not restore delay taps already loaded.

## Timing
- Reset values: `busy`, `done`, `delay_load`, `delay_reg`, `delay_select`, `lane_fail`, `lane_tap` are all 0.
- All outputs are registered.
- `delay_reg` and `delay_select` are stable one cycle before `delay_load` rises, and stay stable until the next SETUP.
- `start` accepted at cycle 0 → `busy`=1 at cycle 1.
- Cycles per tap with valid held high = 1 + 1 + SETTLE_CYCLES + SAMPLE_COUNT + 1 (83 with the defaults).
- Total time with valid held high and `delay_rdy`=1 is deterministic: NUM_LANES × (2^TAP_BITS × per-tap + 2 + SETTLE_CYCLES) plus the state-transition cycles. The bench checks the exact count.

## Structure
- Package `isla_calib_pkg` holds:
  - the state enum;
  - default constants for lane count, tap width and pattern;
  - width helpers for the run length (TAP_BITS+1).
- Sub-module `isla_eye_tracker` holds the run/best registers and the centre computation. It has three controls: clear, pass, and tap-strobe.
- The top level holds the FSM, the settle/sample counters and the result registers.

## Test plan
- Test parameters: SETTLE_CYCLES=2, SAMPLE_COUNT=4.
- All lanes always match the pattern → every `lane_tap` = 15 (window 0..31), `lane_fail` = 0, one `done` pulse.
- Lane 3 passes only at taps 10..17, other lanes always pass → lane 3 tap 13, other lanes 15.
- Lane 0 passes at 2..5 and 20..23 (equal windows) → 3. Lane 0 passes at 2..5 and 20..24 → 22.
- Lane 5 never matches → `lane_fail` = 8'h20, `lane_tap` lane 5 = DEFAULT_TAP, other lanes unaffected.
- `delay_rdy` held low for 50 cycles, with a second `start` pulsed mid-run → no `delay_load` before `delay_rdy`, the second `start` is ignored, exactly 8×33 load edges in total.
- `adc_data_valid` toggling at a 25% duty, then `rst` asserted mid-SAMPLE of lane 2 → the result equals the always-valid run; after reset all outputs are 0 asynchronously, and a new `start` runs cleanly from lane 0.
